display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 27 ++
 rtl/hex_to_seg.sv | 11 +
 rtl/display_scan_ctrl.sv | 97 +++++++++
 tb/tb_display_scan_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner:
// segment bit positions, the hex glyph table and the default slot size.
package display_pkg;

  localparam int DEF_SLOT_LOG2 = 3;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Entry n is the {A..G} glyph for nibble n; b and d are lowercase.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to seven-segment glyph decoder, {A..G} active-high.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = glyph(nibble);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with PWM brightness, double-buffered
// value, leading-zero blanking and a frame-end strobe.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SLOT_LOG2 = DEF_SLOT_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [15:0]          data,
  input  logic                 load,
  input  logic [SLOT_LOG2-1:0] brightness,
  input  logic                 blank_lz,
  input  logic [3:0]           dp_mask,
  output logic [3:0]           anodes,
  output logic [7:0]           seg,
  output logic                 frame_done
);

  logic [SLOT_LOG2-1:0] p;
  logic [1:0]           d;
  logic [15:0]          active;
  logic [15:0]          shadow;
  logic                 pending;

  logic       frame_end;
  logic       lit;
  logic       upper_zero;
  logic       blank;
  logic [3:0] nibble;
  logic [6:0] glyph_segs;
  logic [3:0] an_next;
  logic [7:0] seg_next;

  assign frame_end = tick && (d == 2'd0) && (p == '1);
  assign nibble    = active[4*d +: 4];
  assign lit       = (p != '0) && (p <= brightness);

  // Blank only while this digit and everything to its left is zero.
  always_comb begin
    upper_zero = 1'b0;
    case (d)
      2'd3:    upper_zero = (active[15:12] == 4'h0);
      2'd2:    upper_zero = (active[15:8] == 8'h00);
      2'd1:    upper_zero = (active[15:4] == 12'h000);
      default: upper_zero = 1'b0;
    endcase
  end

  assign blank = blank_lz && upper_zero;

  hex_to_seg u_hex (
    .nibble (nibble),
    .segs   (glyph_segs)
  );

  always_comb begin
    an_next  = 4'b0000;
    seg_next = 8'h00;
    if (lit) begin
      an_next  = 4'b0001 << d;
      seg_next = {blank ? 7'h00 : glyph_segs, dp_mask[d]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p          <= '0;
      d          <= 2'd3;
      active     <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      anodes     <= 4'b0000;
      seg        <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (tick) begin
        anodes <= an_next;
        seg    <= seg_next;
        p      <= p + 1'b1;
        if (p == '1) d <= d - 2'd1;
      end
      if (load) shadow <= data;
      // Swap buffers only between frames so a digit never tears mid-scan.
      if (frame_end) begin
        if (load)         active <= data;
        else if (pending) active <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized and directed check of display_scan_ctrl against a
// frame-level reference model of the scan, blanking and buffering rules.
module tb_display_scan_ctrl;

  localparam int SL   = 3;
  localparam int PMAX = (1 << SL) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [15:0]   data;
  logic          load;
  logic [SL-1:0] brightness;
  logic          blank_lz;
  logic [3:0]    dp_mask;
  logic [3:0]    anodes;
  logic [7:0]    seg;
  logic          frame_done;

  display_scan_ctrl #(.SLOT_LOG2(SL)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .data       (data),
    .load       (load),
    .brightness (brightness),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .anodes     (anodes),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fd  = 0;

  int m_p, m_d;
  int m_active, m_shadow, m_pend;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic       e_fd;

  string glyph_txt [16] = '{
    "ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
    "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"
  };

  function automatic logic [7:0] glyph_bits(input int n);
    logic [7:0] r;
    string s;
    r = 8'h00;
    s = glyph_txt[n];
    for (int i = 0; i < s.len(); i++)
      r[7 - (s[i] - "A")] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s p=%0d d=%0d obs=%h exp=%h", tag, m_p, m_d, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit t, input bit ld,
                            input int dat);
    bit fe;
    int nib;
    if (r) begin
      e_an = 0; e_seg = 0; e_fd = 0;
      m_active = 0; m_shadow = 0; m_pend = 0; m_d = 3; m_p = 0;
      return;
    end
    fe   = t && m_d == 0 && m_p == PMAX;
    e_fd = fe;
    if (t) begin
      e_an = 0; e_seg = 0;
      if (m_p >= 1 && m_p <= int'(brightness)) begin
        e_an = 4'(1 << m_d);
        nib  = (m_active >> (4 * m_d)) & 15;
        if (!(blank_lz && m_d > 0 && (m_active >> (4 * m_d)) == 0))
          e_seg = glyph_bits(nib);
        e_seg[0] = dp_mask[m_d];
      end
      if (m_p == PMAX) begin
        m_p = 0;
        m_d = (m_d + 3) % 4;
      end else begin
        m_p++;
      end
    end
    if (fe) begin
      if (ld) m_active = dat;
      else if (m_pend) m_active = m_shadow;
      m_pend = 0;
    end else if (ld) begin
      m_pend = 1;
    end
    if (ld) m_shadow = dat;
  endtask

  task automatic step(input bit r, input bit t, input bit ld, input int dat);
    rst  = r;
    tick = t;
    load = ld;
    data = 16'(dat);
    @(posedge clk);
    model_edge(r, t, ld, dat);
    #1;
    rst = 1'b0; tick = 1'b0; load = 1'b0;
    chk("anodes", {4'h0, anodes}, {4'h0, e_an});
    chk("seg", seg, e_seg);
    chk("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    if (frame_done) n_fd++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  task automatic until_slot(input int d, input int p);
    int guard = 0;
    while (!(m_d == d && m_p == p) && guard < 64) begin
      step(0, 1, 0, 0);
      guard++;
    end
    n_cmp++;
    if (guard >= 64) begin
      n_bad++;
      $error("FAIL until_slot timeout d=%0d p=%0d", d, p);
    end
  endtask

  initial begin
    int fd0;
    rst = 1'b1; tick = 1'b0; load = 1'b0; data = 16'h0;
    brightness = 3'd7; blank_lz = 1'b0; dp_mask = 4'h0;

    // Reset with competing tick/load
    step(1, 1, 1, 16'hFFFF);
    step(1, 0, 0, 0);

    // 1234 at full brightness: first frame shows zero, next shows 1234
    step(0, 0, 1, 16'h1234);
    fd0 = n_fd;
    ticks(64);
    chk("fd_count_2frames", 8'(n_fd - fd0), 8'd2);

    // brightness 3 and 0, with decimal points
    brightness = 3'd3; dp_mask = 4'b1010;
    ticks(32);
    brightness = 3'd0;
    ticks(32);
    brightness = 3'd5; dp_mask = 4'h0;

    // Mid-frame loads: latest wins at next frame
    until_slot(2, 3);
    step(0, 1, 1, 16'hAAAA);
    until_slot(1, 2);
    step(0, 0, 1, 16'h5555);
    ticks(40);
    chk("active_5555", 8'(m_active == 16'h5555), 8'(dut.active == 16'h5555));

    // Leading-zero blanking
    blank_lz = 1'b1; dp_mask = 4'b1100; brightness = 3'd7;
    step(0, 0, 1, 16'h0070);
    ticks(64);
    step(0, 0, 1, 16'h0000);
    ticks(64);

    // Reset mid-frame at d=1 p=4
    until_slot(1, 4);
    step(1, 0, 0, 0);
    ticks(12);

    // Load on the frame-end tick
    until_slot(0, PMAX);
    step(0, 1, 1, 16'hBEEF);
    chk("pending_after_fe", {7'h0, dut.pending}, 8'h00);
    ticks(34);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom);
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0,
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom & 16'hFFFF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
